// File: rtl/turbo_ber_meter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | turbo_ber_meter : bit/frame error meter, reference FIFO vs decoder   |
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
module turbo_ber_meter #(
  parameter int pDAT_W  = 1,
  parameter int pADDR_W = 12,
  parameter int pCNT_W  = 32,
  parameter int pEST_W  = 16
) (
  input  logic              iclk,
  input  logic              ireset,
  input  logic              iclkena,
  input  logic              istart,
  input  logic              iclear,
  input  logic [pCNT_W-1:0] iNpkt,
  input  logic              iref_sop,
  input  logic              iref_eop,
  input  logic              iref_val,
  input  logic [pDAT_W-1:0] iref_dat,
  input  logic              idec_sop,
  input  logic              idec_eop,
  input  logic              idec_val,
  input  logic [pDAT_W-1:0] idec_dat,
  input  logic [pEST_W-1:0] idec_err,
  output logic              obusy,
  output logic              odone,
  output logic              ofrm_val,
  output logic [pCNT_W-1:0] ofrm_nerr,
  output logic [pCNT_W-1:0] obits,
  output logic [pCNT_W-1:0] onumerr,
  output logic [pCNT_W-1:0] ofrm_err,
  output logic [pCNT_W-1:0] opkt,
  output logic [pCNT_W-1:0] oest_err,
  output logic              oovf,
  output logic              ounf
);

  localparam int c_DEPTH = 2**pADDR_W;
  localparam int c_PC_W  = $clog2(pDAT_W + 1);
  localparam int c_SUM_W = ((pCNT_W > pEST_W) ? pCNT_W : pEST_W) + 6;
  localparam logic [pCNT_W-1:0] c_CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic [pDAT_W-1:0]  r_mem [c_DEPTH];
  logic [pADDR_W:0]   r_wptr, r_rptr;
  logic               r_ref_inf, r_dec_inf;
  logic [pCNT_W-1:0]  r_npkt;
  logic               r_s1_val, r_s1_sop, r_s1_eop;
  logic [c_PC_W-1:0]  r_s1_pc;
  logic [pEST_W-1:0]  r_s1_est;
  logic [pCNT_W-1:0]  r_facc;
  logic               r_frm_val, r_ovf, r_unf;
  logic [pCNT_W-1:0]  r_frm_nerr, r_bits, r_numerr, r_frm_err, r_pkt, r_est_err;

  logic               w_run, w_ref_acc, w_dec_acc, w_empty, w_full;
  logic               w_push, w_pop, w_ovf, w_unf, w_frm_done;
  logic [pDAT_W-1:0]  w_fifo_q, w_diff;
  logic [c_PC_W-1:0]  w_pc;
  logic [pCNT_W-1:0]  w_frm_tot, w_pkt_nxt;

  function automatic logic [pCNT_W-1:0] f_sat_add(input logic [pCNT_W-1:0] a,
                                                  input logic [c_SUM_W-1:0] b);
    logic [c_SUM_W-1:0] s;
    s = c_SUM_W'(a) + b;
    if (s > c_SUM_W'(c_CNT_MAX)) return c_CNT_MAX;
    return s[pCNT_W-1:0];
  endfunction

  // Words count only in RUN and only from a sop up to and including eop.
  assign w_run     = (r_state == ST_RUN);
  assign w_ref_acc = w_run & iref_val & (iref_sop | r_ref_inf);
  assign w_dec_acc = w_run & idec_val & (idec_sop | r_dec_inf);

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[pADDR_W-1:0] == r_rptr[pADDR_W-1:0]) &
                   (r_wptr[pADDR_W] != r_rptr[pADDR_W]);
  assign w_pop   = w_dec_acc & ~w_empty;
  assign w_push  = w_ref_acc & (~w_full | w_pop);
  assign w_ovf   = w_ref_acc & w_full & ~w_pop;
  assign w_unf   = w_dec_acc & w_empty;

  assign w_fifo_q = r_mem[r_rptr[pADDR_W-1:0]];
  assign w_diff   = idec_dat ^ w_fifo_q;

  always_comb begin
    w_pc = '0;
    for (int i = 0; i < pDAT_W; i++) w_pc = w_pc + c_PC_W'(w_diff[i]);
  end

  // A sop restarts the frame total, discarding any partial accumulation.
  assign w_frm_tot  = f_sat_add(r_s1_sop ? '0 : r_facc, c_SUM_W'(r_s1_pc));
  assign w_pkt_nxt  = f_sat_add(r_pkt, c_SUM_W'(1));
  assign w_frm_done = r_s1_val & r_s1_eop;

  always_comb begin
    w_state_nxt = r_state;
    if (iclear) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (istart) w_state_nxt = ST_RUN;
        ST_RUN:  if (w_frm_done && (r_npkt != '0) && (w_pkt_nxt == r_npkt))
                   w_state_nxt = ST_DONE;
        ST_DONE: if (istart) w_state_nxt = ST_RUN;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset)       r_state <= ST_IDLE;
    else if (iclkena) r_state <= w_state_nxt;
  end

  always_ff @(posedge iclk) begin
    if (iclkena && w_push) r_mem[r_wptr[pADDR_W-1:0]] <= iref_dat;
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      r_wptr <= '0;  r_rptr <= '0;  r_ref_inf <= 1'b0;  r_dec_inf <= 1'b0;
      r_npkt <= '0;  r_ovf <= 1'b0;  r_unf <= 1'b0;
      r_s1_val <= 1'b0;  r_s1_sop <= 1'b0;  r_s1_eop <= 1'b0;
      r_s1_pc <= '0;  r_s1_est <= '0;  r_facc <= '0;  r_frm_val <= 1'b0;
      r_frm_nerr <= '0;  r_bits <= '0;  r_numerr <= '0;
      r_frm_err <= '0;  r_pkt <= '0;  r_est_err <= '0;
    end else if (iclkena) begin
      if (iclear) begin
        r_wptr <= '0;  r_rptr <= '0;  r_ref_inf <= 1'b0;  r_dec_inf <= 1'b0;
        r_npkt <= '0;  r_ovf <= 1'b0;  r_unf <= 1'b0;
        r_s1_val <= 1'b0;  r_facc <= '0;  r_frm_val <= 1'b0;
        r_frm_nerr <= '0;  r_bits <= '0;  r_numerr <= '0;
        r_frm_err <= '0;  r_pkt <= '0;  r_est_err <= '0;
      end else begin
        if (istart && !w_run) r_npkt <= iNpkt;
        if (w_run && iref_val) r_ref_inf <= (iref_sop | r_ref_inf) & ~iref_eop;
        if (w_run && idec_val) r_dec_inf <= (idec_sop | r_dec_inf) & ~idec_eop;
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_pop)  r_rptr <= r_rptr + 1'b1;
        if (w_ovf)  r_ovf <= 1'b1;
        if (w_unf)  r_unf <= 1'b1;

        r_s1_val <= w_pop;
        r_s1_sop <= idec_sop;
        r_s1_eop <= idec_eop;
        r_s1_pc  <= w_pc;
        r_s1_est <= idec_err;

        // Stage 2 keeps retiring in-flight words even after leaving RUN.
        r_frm_val <= w_frm_done;
        if (r_s1_val) begin
          r_facc <= w_frm_tot;
          r_bits <= f_sat_add(r_bits, c_SUM_W'(pDAT_W));
          if (r_s1_eop) begin
            r_frm_nerr <= w_frm_tot;
            r_numerr   <= f_sat_add(r_numerr, c_SUM_W'(w_frm_tot));
            r_pkt      <= w_pkt_nxt;
            r_frm_err  <= f_sat_add(r_frm_err, c_SUM_W'(w_frm_tot != '0));
            r_est_err  <= f_sat_add(r_est_err, c_SUM_W'(r_s1_est));
          end
        end
      end
    end
  end

  assign obusy     = (r_state == ST_RUN);
  assign odone     = (r_state == ST_DONE);
  assign ofrm_val  = r_frm_val;
  assign ofrm_nerr = r_frm_nerr;
  assign obits     = r_bits;
  assign onumerr   = r_numerr;
  assign ofrm_err  = r_frm_err;
  assign opkt      = r_pkt;
  assign oest_err  = r_est_err;
  assign oovf      = r_ovf;
  assign ounf      = r_unf;

endmodule
`default_nettype wire

// File: doc/turbo_ber_meter.md
Name: turbo_ber_meter

Overview:
- Synthesizable bit-error/frame-error meter for hardware-in-loop BER runs of the turbo encoder/decoder chain.
- A reference stream is captured from the encoder input side into an internal reference FIFO.
- Decoder output words are popped against that FIFO and compared, `pDAT_W` bits per word.
- Accumulates bits, bit errors, frame errors, packets and the decoder's own error estimate until a programmed packet count is reached, then reports done.

Parameters:
- pDAT_W, 1, bits per data word on both streams (1..16).
- pADDR_W, 12, reference FIFO address width; depth = 2**pADDR_W words.
- pCNT_W, 32, width of all accumulating counters.
- pEST_W, 16, width of decoder error-estimate input.

Ports:
- iclk in 1 clock.
- ireset in 1 asynchronous reset, active-high.
- iclkena in 1 clock enable; all state frozen when low.
- istart in 1 start measurement (pulse).
- iclear in 1 synchronous clear of counters, flags and FIFO; returns to IDLE.
- iNpkt in pCNT_W target packet count (sampled on istart; 0 means unlimited).
- iref_sop/iref_eop/iref_val in 1 each, reference frame strobes.
- iref_dat in pDAT_W reference data.
- idec_sop/idec_eop/idec_val in 1 each, decoded frame strobes.
- idec_dat in pDAT_W decoded data.
- idec_err in pEST_W decoder error estimate, valid with idec_val&idec_eop.
- obusy out 1 high in RUN.
- odone out 1 high in DONE.
- ofrm_val out 1 one-cycle pulse per completed frame.
- ofrm_nerr out pCNT_W bit errors of that frame, valid with ofrm_val.
- obits/onumerr/ofrm_err/opkt/oest_err out pCNT_W totals.
- oovf out 1 sticky reference FIFO overflow.
- ounf out 1 sticky underflow.

Behaviour:
- Reset: every output 0; FSM IDLE; FIFO empty; `iNpkt` latch 0.
- FSM IDLE -> RUN on istart.
  - RUN -> DONE when a frame completes and the new opkt equals the latched `iNpkt` (`iNpkt` ≠ 0).
  - DONE -> RUN on istart (counters kept; new target latched).
  - iclear from any state -> IDLE, counters and flags 0, FIFO flushed.
  - iclear has priority over istart in the same cycle.
  - istart in RUN is ignored.
- Framing: a word is in-frame from a val&sop word through the val&eop word inclusive; sop&eop on one word is a 1-word frame.
  - val words outside a frame are ignored on each stream: no FIFO write/pop, not counted.
- Reference side, in RUN only: each in-frame iref word is written to the FIFO.
  - Write when full: word dropped, oovf set.
  - Write and pop in the same cycle while full is legal, no overflow.
- Decoded side, in RUN only: each in-frame idec word pops one FIFO word.
  - Only words written in earlier cycles are visible.
  - Pop on empty (including a same-cycle write into an empty FIFO) sets ounf; that word is excluded from all counts.
- Pipeline: stage 1 registers popcount(idec_dat XOR fifo word) and frame strobes; stage 2 updates the per-frame accumulator and obits.
  - On the eop word, stage 2 also drives ofrm_val=1 and ofrm_nerr = frame total, 2 cycles after the eop word is accepted.
  - In the same cycle: onumerr += frame total, opkt += 1, ofrm_err += (total≠0), oest_err += idec_err (zero-extended, captured at eop).
- An idec sop arriving mid-frame discards the partial frame accumulator (its bits stay in obits/onumerr as already counted) and starts a new frame; no packet is counted for the discarded frame.
- All counters saturate at all-ones and do not wrap.
- FIFO pointers are pADDR_W+1 bits with wrap bit; full = equal address, differing wrap bit.
- After RUN→DONE, further input words are ignored, and stage-1/2 results already in flight still retire.

Test Plan:
- pDAT_W=1, iNpkt=4: 4 identical 1784-bit frames -> opkt=4, obits=7136, onumerr=0, ofrm_err=0, odone=1 two cycles after last eop.
- Frame 2 with bits 0, 100, 1783 flipped, idec_err=3 -> ofrm_nerr=3 pulse for frame 2, onumerr=3, ofrm_err=1, oest_err=3.
- pDAT_W=4, one 8-word frame, decoded word 5 = ref XOR 4'b1011 -> obits=32, onumerr=3.
- pADDR_W=2: 5 reference words with no decoded traffic -> oovf=1, FIFO holds 4; then a decoded frame of 5 words -> ounf=1, obits=4.
- Decoded sop at word 3 of a 10-word frame, then a full 10-word frame -> opkt=1, ofrm_val pulses once.
- pCNT_W=4: 20 bit errors in one frame -> onumerr=15, ofrm_nerr=15; iclear -> all counters 0, state IDLE; ireset mid-frame -> outputs 0 immediately.
